serial_subtractor_n_bit: RTL and testbench
==========================================

Name: serial_subtractor_n_bit

Overview:
Bit-serial N-bit subtractor, the inverse operation of the team's N-bit full adder. It computes a - b - b_in one bit per clock, LSB first, using a single full-subtractor cell and shift registers. A start/busy/done handshake lets a controller or testbench launch an operation and collect the registered difference and borrow-out.

Parameters:
WIDTH, 4, operand and result width in bits (>= 1).
CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only when not busy
a  input  WIDTH  minuend; sampled on the accepted-start edge
b  input  WIDTH  subtrahend; sampled on the accepted-start edge
b_in  input  1  borrow-in; sampled on the accepted-start edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result valid
d  output  WIDTH  registered difference
b_out  output  1  registered borrow-out

Behaviour:
- One clock domain. Reset is synchronous and active-low: on any rising edge with rst_n=0, all state clears.
- Reset values: state=IDLE, busy=0, done=0, d=0, b_out=0; internal shift registers, borrow flop and counter are 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: busy=0. If start=1, latch a, b and b_in into the A/B shift registers and the borrow flop, clear the counter, and go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - diff_bit = A[0]^B[0]^brw; brw_next = (~A[0]&B[0]) | (~(A[0]^B[0])&brw).
    - Shift diff_bit into the MSB of the result shift register (right shift); shift A and B right by 1; increment the counter.
    - After the WIDTH-th SHIFT cycle, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. d and b_out were loaded on the edge entering DONE. If start=1, accept a new operation (latch, go to SHIFT); otherwise go to IDLE.
- Latency: start accepted at edge k; done=1 during the cycle after edge k+WIDTH. The next accepted start can be at edge k+WIDTH+1, giving one result every WIDTH+1 cycles.
- start while in SHIFT is ignored; a, b and b_in changes during SHIFT have no effect.
- d and b_out update only on the edge entering DONE and hold their values until the next completion or reset.
- Arithmetic: d = (a - b - b_in) mod 2^WIDTH; b_out = 1 iff a < b + b_in (unsigned). No overflow flag.
- Reset mid-operation: returns to IDLE in one edge and clears d and b_out; the partial result is discarded, and done does not pulse.
- WIDTH=1 is legal: a single SHIFT cycle.

Test Plan:
- Reset, then a=4'b0101, b=4'b0011, b_in=0, start one cycle -> busy for 4 cycles, then done pulse; d=4'b0010, b_out=0.
- a=0, b=1, b_in=0 -> d=4'b1111, b_out=1. Also a=0, b=0, b_in=1 -> d=4'b1111, b_out=1. Also a=4'b1111, b=4'b1111, b_in=1 -> d=4'b1111, b_out=1.
- Exhaustive sweep: all 16x16x2 combinations, back-to-back starts in the DONE cycle -> every result matches the reference model; done pulses exactly every 5 cycles.
- Assert start with new operands during SHIFT -> ignored; the result equals the original operation; busy profile unchanged.
- Drive rst_n=0 for one edge during the 2nd SHIFT cycle -> next cycle busy=0, d=0, b_out=0, no done pulse; a fresh start afterwards yields a correct result.
- WIDTH=1 instance: a=0, b=1, b_in=1 -> d=0, b_out=1; done two edges after start.

Source files
------------

// File: rtl/serial_subtractor_n_bit_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives start and the operands; the slave returns status and result.
interface serial_subtractor_n_bit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;

  modport master (
    output start, a, b, b_in,
    input  busy, done, d, b_out
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, d, b_out
  );
endinterface

// File: rtl/serial_subtractor_n_bit.sv
// Bit-serial N-bit subtractor: computes a - b - b_in LSB first with a single
// full-subtractor cell, presenting the registered difference and borrow-out.
module serial_subtractor_n_bit #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_subtractor_n_bit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             b_out_q, b_out_d;

  logic             diff_bit;
  logic             brw_nxt;
  logic             last_bit;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res_shifted;

  // Full-subtractor cell on the current LSBs.
  assign diff_bit = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Widened concat keeps the right shift legal when WIDTH is 1.
  assign res_ext     = {diff_bit, res_q};
  assign res_shifted = res_ext[WIDTH:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q == SHIFT);
    bus.done  = (state_q == DONE);
    bus.d     = d_q;
    bus.b_out = b_out_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    b_out_d = b_out_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          brw_d = bus.b_in;
          res_d = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nxt;
        res_d = res_shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          d_d     = res_shifted;
          b_out_d = brw_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      b_out_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      b_out_q <= b_out_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_n_bit.sv
// Self-checking bench for serial_subtractor_n_bit: WIDTH=4 scoreboarded
// sweep plus directed cases, and a WIDTH=1 instance.
module tb_serial_subtractor_n_bit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_n_bit_if #(.WIDTH(4)) s4 ();
  serial_subtractor_n_bit_if #(.WIDTH(1)) s1 ();

  serial_subtractor_n_bit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(s4));
  serial_subtractor_n_bit #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(s1));

  int checks = 0;
  int errors = 0;

  logic [4:0] sb[$];
  longint     done_times[$];
  longint     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done pulse pops one expected {b_out, d}.
  always @(negedge clk) begin
    logic [4:0] exp_v;
    if (s4.done === 1'b1) begin
      done_times.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: done pulse with no expected result at cycle %0d", cyc);
      end else begin
        exp_v = sb.pop_front();
        if ({s4.b_out, s4.d} !== exp_v) begin
          errors++;
          $display("FAIL sb_result: got b_out=%b d=%b, expected b_out=%b d=%b",
                   s4.b_out, s4.d, exp_v[4], exp_v[3:0]);
        end
      end
    end
  end

  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch from IDLE or DONE; returns one tick into the first SHIFT cycle.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic bin);
    s4.a     = a;
    s4.b     = b;
    s4.b_in  = bin;
    s4.start = 1'b1;
    step();
    s4.start = 1'b0;
    sb.push_back(model(a, b, bin));
    checks++;
    if (s4.busy !== 1'b1) begin
      errors++;
      $display("FAIL issue_busy: busy=%b required 1 (a=%h b=%h bin=%b)", s4.busy, a, b, bin);
    end
  endtask

  // Runs the remaining SHIFT cycles and stops in the DONE cycle.
  task automatic finish_op();
    repeat (3) begin
      step();
      checks++;
      if (s4.busy !== 1'b1 || s4.done !== 1'b0) begin
        errors++;
        $display("FAIL shift_profile: busy=%b done=%b required busy=1 done=0", s4.busy, s4.done);
      end
    end
    step();
    checks++;
    if (s4.busy !== 1'b0 || s4.done !== 1'b1) begin
      errors++;
      $display("FAIL done_profile: busy=%b done=%b required busy=0 done=1", s4.busy, s4.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s4.start = 1'b0; s4.a = '0; s4.b = '0; s4.b_in = 1'b0;
    s1.start = 1'b0; s1.a = '0; s1.b = '0; s1.b_in = 1'b0;
    repeat (2) step();
    checks++;
    if (s4.busy !== 1'b0 || s4.done !== 1'b0 || s4.d !== 4'h0 || s4.b_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b d=%b b_out=%b required all 0",
               s4.busy, s4.done, s4.d, s4.b_out);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [3:0] ta[4] = '{4'b0101, 4'b0000, 4'b0000, 4'b1111};
    logic [3:0] tb[4] = '{4'b0011, 4'b0001, 4'b0000, 4'b1111};
    logic       tc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] td[4] = '{4'b0010, 4'b1111, 4'b1111, 4'b1111};
    logic       te[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], tc[i]);
      finish_op();
      checks++;
      if (s4.d !== td[i] || s4.b_out !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d: d=%b b_out=%b required d=%b b_out=%b",
                 i, s4.d, s4.b_out, td[i], te[i]);
      end
      step();
      checks++;
      if (s4.done !== 1'b0 || s4.busy !== 1'b0 || s4.d !== td[i]) begin
        errors++;
        $display("FAIL idle_hold_%0d: done=%b busy=%b d=%b required 0 0 %b",
                 i, s4.done, s4.busy, s4.d, td[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first;
    first = done_times.size();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          issue(4'(a), 4'(b), 1'(c));
          finish_op();
        end
    step();
    checks++;
    if (done_times.size() - first != 512) begin
      errors++;
      $display("FAIL sweep_count: %0d done pulses, required 512", done_times.size() - first);
    end
    for (int i = first + 1; i < done_times.size(); i++) begin
      if (done_times[i] - done_times[i-1] != 5) begin
        checks++;
        errors++;
        $display("FAIL sweep_spacing: pulse %0d spacing %0d, required 5",
                 i - first, done_times[i] - done_times[i-1]);
      end
    end
    checks++;
    if (done_times.size() > first + 1 &&
        done_times[done_times.size()-1] - done_times[first] != 511 * 5) begin
      errors++;
      $display("FAIL sweep_span: span %0d, required %0d",
               done_times[done_times.size()-1] - done_times[first], 511 * 5);
    end
  endtask

  task automatic test_start_during_shift();
    issue(4'b1010, 4'b0011, 1'b1);
    s4.a = 4'b0001; s4.b = 4'b1110; s4.b_in = 1'b0; s4.start = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (s4.busy !== 1'b1 || s4.done !== 1'b0) begin
        errors++;
        $display("FAIL ignore_profile: busy=%b done=%b required busy=1 done=0", s4.busy, s4.done);
      end
    end
    s4.start = 1'b0;
    step();
    checks++;
    if (s4.done !== 1'b1 || s4.d !== 4'b0110 || s4.b_out !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: done=%b d=%b b_out=%b required done=1 d=0110 b_out=0",
               s4.done, s4.d, s4.b_out);
    end
    step();
    checks++;
    if (s4.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: busy=%b required 0", s4.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(4'b1000, 4'b0001, 1'b0);
    finish_op();
    step();
    issue(4'b1100, 4'b0101, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb.delete();
    checks++;
    if (s4.busy !== 1'b0 || s4.done !== 1'b0 || s4.d !== 4'h0 || s4.b_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b d=%b b_out=%b required all 0",
               s4.busy, s4.done, s4.d, s4.b_out);
    end
    repeat (6) begin
      step();
      if (s4.done !== 1'b0 || s4.busy !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL midreset_quiet: done=%b busy=%b required 0 0", s4.done, s4.busy);
      end
    end
    issue(4'b0111, 4'b0010, 1'b1);
    finish_op();
    checks++;
    if (s4.d !== 4'b0100 || s4.b_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fresh: d=%b b_out=%b required d=0100 b_out=0", s4.d, s4.b_out);
    end
    step();
  endtask

  task automatic test_width1();
    s1.a = 1'b0; s1.b = 1'b1; s1.b_in = 1'b1; s1.start = 1'b1;
    step();
    s1.start = 1'b0;
    checks++;
    if (s1.busy !== 1'b1 || s1.done !== 1'b0) begin
      errors++;
      $display("FAIL w1_shift: busy=%b done=%b required busy=1 done=0", s1.busy, s1.done);
    end
    step();
    checks++;
    if (s1.done !== 1'b1 || s1.busy !== 1'b0 || s1.d !== 1'b0 || s1.b_out !== 1'b1) begin
      errors++;
      $display("FAIL w1_result: done=%b busy=%b d=%b b_out=%b required 1 0 0 1",
               s1.done, s1.busy, s1.d, s1.b_out);
    end
    s1.a = 1'b1; s1.b = 1'b0; s1.b_in = 1'b0; s1.start = 1'b1;
    step();
    s1.start = 1'b0;
    step();
    checks++;
    if (s1.done !== 1'b1 || s1.d !== 1'b1 || s1.b_out !== 1'b0) begin
      errors++;
      $display("FAIL w1_b2b: done=%b d=%b b_out=%b required 1 1 0", s1.done, s1.d, s1.b_out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_during_shift();
    test_reset_mid_op();
    test_width1();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results never produced", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
